// File: rtl/sdram_rd_port.sv
// ---------------------------------------------------------------------------
// sdram_rd_port
// Background read-prefetch port for an SDRAM controller. While prefetch is
// enabled and the local FIFO has room for a whole burst, it raises rd_req
// towards the arbiter/read engine with a start address and burst length.
// Returned words are stored in a FIFO that the user drains via rd_fifo_rd_en.
// The read address walks a circular region [rd_b_addr, rd_e_addr).
//
// Ports
//   rd_clk, rd_rst_n          clock, asynchronous active-low reset
//   init_end, read_valid      SDRAM ready / user prefetch enable
//   rd_b_addr, rd_e_addr      region start (inclusive) / end (exclusive)
//   rd_len                    words per burst
//   rd_fifo_rst               synchronous FIFO flush pulse
//   rd_req, rd_addr,          request, burst start address, burst length
//   rd_burst_len
//   rd_ack, rd_sdram_data,    read engine data strobe, data, burst-done pulse
//   rd_end
//   rd_fifo_rd_en,            user pop, popped word, words held
//   rd_fifo_rd_data,
//   rd_fifo_num
// ---------------------------------------------------------------------------
module sdram_rd_port #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          rd_clk,
    input  logic          rd_rst_n,
    input  logic          init_end,
    input  logic          read_valid,
    input  logic [23:0]   rd_b_addr,
    input  logic [23:0]   rd_e_addr,
    input  logic [9:0]    rd_len,
    input  logic          rd_fifo_rst,
    output logic          rd_req,
    output logic [23:0]   rd_addr,
    output logic [9:0]    rd_burst_len,
    input  logic          rd_ack,
    input  logic [DW-1:0] rd_sdram_data,
    input  logic          rd_end,
    input  logic          rd_fifo_rd_en,
    output logic [DW-1:0] rd_fifo_rd_data,
    output logic [AW:0]   rd_fifo_num
);

    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_REQ  = 2'd1;
    localparam logic [1:0] P_BUSY = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          discard_q, discard_d;
    logic [23:0]   addr_q, addr_d;
    logic [9:0]    blen_q, blen_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   num_q, num_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic [DW-1:0] mem [DEPTH];

    logic          in_burst;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          start;
    logic [31:0]   free_space;
    logic [24:0]   next_addr;

    assign in_burst   = (state_q != P_IDLE);
    assign fifo_full  = (num_q == (AW+1)'(DEPTH));
    assign fifo_empty = (num_q == '0);

    // A flush cycle neither stores nor pops: the FIFO is emptied instead.
    assign push = rd_ack && !fifo_full && !discard_q && !rd_fifo_rst;
    assign pop  = rd_fifo_rd_en && !fifo_empty && !rd_fifo_rst;

    assign free_space = 32'(DEPTH) - 32'(num_q);
    assign start      = init_end && read_valid && !rd_fifo_rst
                        && (free_space >= 32'(rd_len));

    // One extra bit so an address near the top of the map cannot wrap
    // around and look smaller than the region end.
    assign next_addr = {1'b0, addr_q} + {15'b0, blen_q};

    // Request / burst state machine and the flush-discard flag.
    always_comb begin
        state_d   = state_q;
        blen_d    = blen_q;
        discard_d = discard_q;
        case (state_q)
            P_IDLE: begin
                if (start) begin
                    state_d = P_REQ;
                    blen_d  = rd_len;
                end
            end
            P_REQ: begin
                // rd_end before any data is a zero-length burst.
                if (rd_end)
                    state_d = P_IDLE;
                else if (rd_ack)
                    state_d = P_BUSY;
            end
            P_BUSY: begin
                if (rd_end)
                    state_d = P_IDLE;
            end
            default: state_d = P_IDLE;
        endcase

        if (in_burst && rd_end)
            discard_d = 1'b0;
        else if (in_burst && rd_fifo_rst)
            discard_d = 1'b1;
    end

    // Address walk. A flush during a burst only marks the burst as discarded;
    // the address is kept stable for the read engine and rewound at rd_end.
    always_comb begin
        addr_d = addr_q;
        if (!init_end) begin
            addr_d = rd_b_addr;
        end else if (in_burst && rd_end) begin
            if (discard_q || rd_fifo_rst || (next_addr >= {1'b0, rd_e_addr}))
                addr_d = rd_b_addr;
            else
                addr_d = next_addr[23:0];
        end else if (!in_burst && rd_fifo_rst) begin
            addr_d = rd_b_addr;
        end
    end

    // FIFO bookkeeping.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        num_d     = num_q;
        rd_data_d = rd_data_q;
        if (rd_fifo_rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            num_d    = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                rd_data_d = mem[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   num_d = num_q + (AW+1)'(1);
                2'b01:   num_d = num_q - (AW+1)'(1);
                default: num_d = num_q;
            endcase
        end
    end

    always_ff @(posedge rd_clk) begin
        if (push)
            mem[wr_ptr_q] <= rd_sdram_data;
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q   <= P_IDLE;
            discard_q <= 1'b0;
            addr_q    <= '0;
            blen_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            num_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            addr_q    <= addr_d;
            blen_q    <= blen_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            num_q     <= num_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_req          = (state_q == P_REQ);
    assign rd_addr         = addr_q;
    assign rd_burst_len    = blen_q;
    assign rd_fifo_rd_data = rd_data_q;
    assign rd_fifo_num     = num_q;

endmodule

// File: tb/tb_sdram_rd_port.sv
module tb_sdram_rd_port;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n;
    logic          init_end;
    logic          read_valid;
    logic [23:0]   rd_b_addr;
    logic [23:0]   rd_e_addr;
    logic [9:0]    rd_len;
    logic          rd_fifo_rst;
    logic          rd_req;
    logic [23:0]   rd_addr;
    logic [9:0]    rd_burst_len;
    logic          rd_ack;
    logic [DW-1:0] rd_sdram_data;
    logic          rd_end;
    logic          rd_fifo_rd_en;
    logic [DW-1:0] rd_fifo_rd_data;
    logic [AW:0]   rd_fifo_num;

    sdram_rd_port #(.AW(AW), .DW(DW)) dut (
        .rd_clk          (rd_clk),
        .rd_rst_n        (rd_rst_n),
        .init_end        (init_end),
        .read_valid      (read_valid),
        .rd_b_addr       (rd_b_addr),
        .rd_e_addr       (rd_e_addr),
        .rd_len          (rd_len),
        .rd_fifo_rst     (rd_fifo_rst),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_burst_len    (rd_burst_len),
        .rd_ack          (rd_ack),
        .rd_sdram_data   (rd_sdram_data),
        .rd_end          (rd_end),
        .rd_fifo_rd_en   (rd_fifo_rd_en),
        .rd_fifo_rd_data (rd_fifo_rd_data),
        .rd_fifo_num     (rd_fifo_num)
    );

    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: words expected to come out of the FIFO, in order.
    logic [DW-1:0] sb_q[$];
    logic          m_in_burst = 1'b0;
    logic          m_discard  = 1'b0;
    logic [DW-1:0] last_data  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge rd_clk);
        #1;
    endtask

    // One clock of read-engine / user activity, mirrored in the scoreboard.
    task automatic step(input logic ack, input logic [DW-1:0] d, input logic pop, input logic flush);
        logic          do_pop;
        logic [DW-1:0] exp_d;
        do_pop = 1'b0;
        exp_d  = last_data;
        rd_ack = ack; rd_sdram_data = d; rd_fifo_rd_en = pop; rd_fifo_rst = flush;
        if (flush) begin
            sb_q.delete();
            if (m_in_burst) m_discard = 1'b1;
        end else begin
            do_pop = pop && (sb_q.size() > 0);
            if (do_pop) exp_d = sb_q.pop_front();
            if (ack && !m_discard && (sb_q.size() < DEPTH)) sb_q.push_back(d);
        end
        tick;
        rd_ack = 1'b0; rd_fifo_rd_en = 1'b0; rd_fifo_rst = 1'b0;
        if (do_pop) begin
            check("pop_data", 32'(rd_fifo_rd_data), 32'(exp_d));
            last_data = exp_d;
        end else if (pop) begin
            check("pop_empty_hold", 32'(rd_fifo_rd_data), 32'(last_data));
        end
        check("fifo_num", 32'(rd_fifo_num), 32'(sb_q.size()));
    endtask

    task automatic wait_req(input logic [23:0] exp_addr, input int exp_len);
        int w;
        w = 0;
        while (!rd_req && w < 100) begin
            tick;
            w++;
        end
        check("req_seen", 32'(rd_req), 32'd1);
        check("req_addr", 32'(rd_addr), 32'(exp_addr));
        check("req_len", 32'(rd_burst_len), 32'(exp_len));
        $display("burst request addr=%06h len=%0d fifo_num=%0d", rd_addr, rd_burst_len, rd_fifo_num);
    endtask

    task automatic serve_burst(input logic [23:0] exp_addr, input logic [DW-1:0] base,
                               input int n, input int flush_at, input int drop_valid_at);
        wait_req(exp_addr, n);
        m_in_burst = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == drop_valid_at) read_valid = 1'b0;
            step(1'b1, base + DW'(i), 1'b0, (i == flush_at));
            check("addr_stable", 32'(rd_addr), 32'(exp_addr));
        end
        rd_end = 1'b1;
        tick;
        rd_end = 1'b0;
        m_in_burst = 1'b0;
        m_discard  = 1'b0;
        check("req_low_after_end", 32'(rd_req), 32'd0);
    endtask

    initial begin
        logic saw_req;
        rd_rst_n = 1'b0; init_end = 1'b0; read_valid = 1'b0;
        rd_b_addr = 24'h0; rd_e_addr = 24'h000400; rd_len = 10'd256;
        rd_fifo_rst = 1'b0; rd_ack = 1'b0; rd_sdram_data = '0;
        rd_end = 1'b0; rd_fifo_rd_en = 1'b0;
        tick; tick;
        check("rst_req", 32'(rd_req), 32'd0);
        check("rst_addr", 32'(rd_addr), 32'd0);
        check("rst_blen", 32'(rd_burst_len), 32'd0);
        check("rst_data", 32'(rd_fifo_rd_data), 32'd0);
        check("rst_num", 32'(rd_fifo_num), 32'd0);
        rd_rst_n = 1'b1;

        // Before init, the address follows rd_b_addr.
        rd_b_addr = 24'h123456;
        tick;
        check("preinit_addr", 32'(rd_addr), 32'h123456);
        rd_b_addr = 24'h0;
        tick;
        check("preinit_addr0", 32'(rd_addr), 32'h0);

        // Four bursts walk the region and fill the FIFO.
        init_end = 1'b1; read_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            serve_burst(24'(k * 256), 16'h1000 + 16'(k * 256), 256, -1, -1);
            check("num_after_burst", 32'(rd_fifo_num), 32'((k + 1) * 256));
        end

        // No request until free space covers a whole burst (num <= 768).
        saw_req = 1'b0;
        for (int i = 0; i < 255; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (rd_req) saw_req = 1'b1;
        end
        check("no_req_above_768", 32'(saw_req), 32'd0);
        check("num_769", 32'(rd_fifo_num), 32'd769);
        step(1'b0, '0, 1'b1, 1'b0);
        check("no_req_same_cycle", 32'(rd_req), 32'd0);
        tick;
        check("req_at_768", 32'(rd_req), 32'd1);

        // Fifth burst wraps back to the region start.
        serve_burst(24'h0, 16'h5000, 256, -1, -1);
        check("num_full", 32'(rd_fifo_num), 32'd1024);
        read_valid = 1'b0;

        // Flush while idle: FIFO empties, address rewinds.
        step(1'b0, '0, 1'b0, 1'b1);
        check("flush_idle_addr", 32'(rd_addr), 32'h0);

        // Burst of 0xA000.. with read_valid dropping mid-burst, then pop 3.
        read_valid = 1'b1;
        serve_burst(24'h0, 16'hA000, 256, -1, 128);
        tick; tick;
        check("no_req_after_valid_drop", 32'(rd_req), 32'd0);
        check("addr_after_a000", 32'(rd_addr), 32'h100);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("pop3_value", 32'(rd_fifo_rd_data), 32'hA002);
        tick;
        check("data_hold", 32'(rd_fifo_rd_data), 32'hA002);

        // Flush at word 100 of a 256-word burst.
        read_valid = 1'b1;
        serve_burst(24'h100, 16'hB000, 256, 100, -1);
        check("num_after_flush_burst", 32'(rd_fifo_num), 32'd0);
        wait_req(24'h0, 256);
        // Zero-data burst: rd_end straight from the request state.
        read_valid = 1'b0;
        rd_end = 1'b1;
        tick;
        rd_end = 1'b0;
        check("zero_burst_req", 32'(rd_req), 32'd0);
        check("zero_burst_addr", 32'(rd_addr), 32'h100);

        // Pop on empty, then simultaneous push/pop at 5 words.
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
        check("num_5", 32'(rd_fifo_num), 32'd5);
        step(1'b1, 16'hC005, 1'b1, 1'b0);
        check("num_stays_5", 32'(rd_fifo_num), 32'd5);
        check("simul_pop_data", 32'(rd_fifo_rd_data), 32'hC000);

        // Reset during a burst.
        read_valid = 1'b1;
        wait_req(24'h100, 256);
        m_in_burst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0);
        read_valid = 1'b0;
        rd_rst_n = 1'b0;
        sb_q.delete();
        m_in_burst = 1'b0;
        m_discard = 1'b0;
        last_data = '0;
        tick;
        check("midrst_req", 32'(rd_req), 32'd0);
        check("midrst_addr", 32'(rd_addr), 32'd0);
        check("midrst_blen", 32'(rd_burst_len), 32'd0);
        check("midrst_data", 32'(rd_fifo_rd_data), 32'd0);
        check("midrst_num", 32'(rd_fifo_num), 32'd0);
        rd_rst_n = 1'b1;
        tick;
        rd_end = 1'b1;
        tick;
        rd_end = 1'b0;
        tick;
        check("late_end_req", 32'(rd_req), 32'd0);
        check("late_end_addr", 32'(rd_addr), 32'd0);
        check("late_end_num", 32'(rd_fifo_num), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
